// File: rtl/board_store_if.sv
// board_store_if: drop handshake, clear handshake, read port and mark port
// between the checker/controller (master) and the board memory (slave).
`timescale 1ns/1ps
interface board_store_if;
  logic       drop_valid;
  logic       drop_ready;
  logic [2:0] drop_col;
  logic [1:0] drop_player;
  logic       drop_done;
  logic       drop_ok;
  logic [2:0] drop_row;
  logic       clear_req;
  logic       clear_busy;
  logic       clear_done;
  logic [2:0] read_row;
  logic [2:0] read_col;
  logic [1:0] data_out;
  logic       win_out;
  logic [2:0] winning_row;
  logic [2:0] winning_col;
  logic       w_winning_pieces;

  modport master (
    output drop_valid, drop_col, drop_player, clear_req,
           read_row, read_col, winning_row, winning_col, w_winning_pieces,
    input  drop_ready, drop_done, drop_ok, drop_row, clear_busy, clear_done,
           data_out, win_out
  );

  modport slave (
    input  drop_valid, drop_col, drop_player, clear_req,
           read_row, read_col, winning_row, winning_col, w_winning_pieces,
    output drop_ready, drop_done, drop_ok, drop_row, clear_busy, clear_done,
           data_out, win_out
  );
endinterface

// File: rtl/board_store.sv
// board_store: connect-four board memory. Per-column storage (pieces, win
// marks, fill height) lives in board_col instances; the top sequences drops
// and the row-by-row clear sweep and muxes the combinational read port.
// Optional macro BOARD_STORE_FULL_DETECT_EN adds the registered board_full output.
`timescale 1ns/1ps
module board_col #(
  parameter int ROWS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 drop_we,
  input  logic [1:0]           piece,
  input  logic                 mark_we,
  input  logic [2:0]           mark_row,
  input  logic                 clr_row_en,
  input  logic [2:0]           clr_row,
  input  logic                 clr_height,
  output logic [ROWS-1:0][1:0] cells,
  output logic [ROWS-1:0]      marks,
  output logic [3:0]           height
);
  // Cell/mark/height update; row clear overrides writes to the same row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cells  <= '0;
      marks  <= '0;
      height <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (clr_row_en && clr_row == 3'(r)) begin
          cells[r] <= 2'b00;
          marks[r] <= 1'b0;
        end else begin
          if (drop_we && height == 4'(r)) cells[r] <= piece;
          if (mark_we && mark_row == 3'(r)) marks[r] <= 1'b1;
        end
      end
      if (clr_height)   height <= '0;
      else if (drop_we) height <= height + 4'd1;
    end
  end
endmodule

module board_store #(
  parameter int ROWS = 6,
  parameter int COLS = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  board_store_if.slave  bus
`ifdef BOARD_STORE_FULL_DETECT_EN
  ,
  output logic          board_full
`endif
);
  localparam logic [3:0] ROWS_L = 4'(ROWS);
  localparam logic [3:0] COLS_L = 4'(COLS);

  typedef enum logic [1:0] {ST_IDLE, ST_DROP, ST_CLEAR} st_t;

  st_t                             state, nstate;
  logic [2:0]                      cap_col;
  logic [1:0]                      cap_player;
  logic [2:0]                      crow;
  logic [COLS-1:0][ROWS-1:0][1:0]  cells;
  logic [COLS-1:0][ROWS-1:0]       marks;
  logic [COLS-1:0][3:0]            heights;
  logic [3:0]                      cur_h;
  logic                            accept, clr_last, clr_en, mark_en, drop_ready;
  logic                            drop_done_q, drop_ok_q, clear_done_q;
  logic [2:0]                      drop_row_q;
  logic [1:0]                      rd_data;
  logic                            rd_win;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nstate;
  end

  // Next state: clear has priority over a drop in idle; drop is one cycle.
  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:  if (bus.clear_req)       nstate = ST_CLEAR;
                else if (bus.drop_valid) nstate = ST_DROP;
      ST_DROP:  nstate = ST_IDLE;
      ST_CLEAR: if (clr_last)            nstate = ST_IDLE;
      default:  nstate = ST_IDLE;
    endcase
  end

  // Height of the captured column (0 when the column is out of range).
  always_comb begin
    cur_h = '0;
    for (int c = 0; c < COLS; c++)
      if (cap_col == 3'(c)) cur_h = heights[c];
  end

  // State-derived controls and handshake outputs.
  always_comb begin
    drop_ready = (state == ST_IDLE) && !bus.clear_req;
    clr_en     = (state == ST_CLEAR);
    clr_last   = clr_en && (crow == 3'(ROWS-1));
    mark_en    = bus.w_winning_pieces && (state != ST_CLEAR);
    accept     = (state == ST_DROP) && ({1'b0, cap_col} < COLS_L) &&
                 (cur_h < ROWS_L) && (cap_player != 2'b00);
  end

  // Request capture, sweep counter and registered result pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_col      <= '0;
      cap_player   <= '0;
      crow         <= '0;
      drop_done_q  <= 1'b0;
      drop_ok_q    <= 1'b0;
      drop_row_q   <= '0;
      clear_done_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && bus.clear_req) begin
        crow <= '0;
      end else if (bus.drop_valid && drop_ready) begin
        cap_col    <= bus.drop_col;
        cap_player <= bus.drop_player;
      end
      if (clr_en) crow <= crow + 3'd1;
      drop_done_q  <= (state == ST_DROP);
      drop_ok_q    <= accept;
      if (accept) drop_row_q <= cur_h[2:0];
      clear_done_q <= clr_last;
    end
  end

  // One storage column per board column.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    board_col #(.ROWS(ROWS)) u_col (
      .clk        (clk),
      .rst_n      (rst_n),
      .drop_we    (accept && cap_col == 3'(c)),
      .piece      (cap_player),
      .mark_we    (mark_en && bus.winning_col == 3'(c)),
      .mark_row   (bus.winning_row),
      .clr_row_en (clr_en),
      .clr_row    (crow),
      .clr_height (clr_last),
      .cells      (cells[c]),
      .marks      (marks[c]),
      .height     (heights[c])
    );
  end

  // Combinational read; addresses outside the board read as empty.
  always_comb begin
    rd_data = 2'b00;
    rd_win  = 1'b0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (bus.read_col == 3'(c) && bus.read_row == 3'(r)) begin
          rd_data = cells[c][r];
          rd_win  = marks[c][r];
        end
  end

`ifdef BOARD_STORE_FULL_DETECT_EN
  logic all_full;

  // Every column at full height.
  always_comb begin
    all_full = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (heights[c] != ROWS_L) all_full = 1'b0;
  end

  // Registered full flag, dropped when a clear completes.
  always_ff @(posedge clk) begin
    if (!rst_n)        board_full <= 1'b0;
    else if (clr_last) board_full <= 1'b0;
    else               board_full <= all_full;
  end
`endif

  assign bus.drop_ready = drop_ready;
  assign bus.drop_done  = drop_done_q;
  assign bus.drop_ok    = drop_ok_q;
  assign bus.drop_row   = drop_row_q;
  assign bus.clear_busy = clr_en;
  assign bus.clear_done = clear_done_q;
  assign bus.data_out   = rd_data;
  assign bus.win_out    = rd_win;
endmodule

// File: tb/tb_board_store.sv
// tb_board_store: directed bench for board_store with a drop-result
// scoreboard and a reference board model.
`timescale 1ns/1ps
module tb_board_store;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  board_store_if bus();
`ifdef BOARD_STORE_FULL_DETECT_EN
  logic board_full;
`endif

  board_store dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BOARD_STORE_FULL_DETECT_EN
    ,
    .board_full (board_full)
`endif
  );

  typedef struct packed {logic ok; logic [2:0] row;} exp_t;
  exp_t       sbq[$];
  int         total = 0;
  int         bad = 0;
  int         mh[8];
  logic [1:0] mcell[8][8];
  logic       mmark[8][8];
  logic [2:0] mlast;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 8; r++) begin
      mh[r] = 0;
      for (int c = 0; c < 8; c++) begin
        mcell[r][c] = 2'b00;
        mmark[r][c] = 1'b0;
      end
    end
  endtask

  task automatic rd(input int r, input int c);
    bus.read_row = 3'(r);
    bus.read_col = 3'(c);
    #1;
    chk($sformatf("rd_data(%0d,%0d)", r, c), 32'(bus.data_out), 32'(mcell[r][c]));
    chk($sformatf("rd_win(%0d,%0d)", r, c), 32'(bus.win_out), 32'(mmark[r][c]));
  endtask

  task automatic check_all();
    @(negedge clk);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) rd(r, c);
  endtask

  task automatic drop(input int col, input int pl);
    exp_t e;
    int   lat;
    bit   seen;
    @(negedge clk);
    bus.drop_valid  = 1'b1;
    bus.drop_col    = 3'(col);
    bus.drop_player = 2'(pl);
    #1 chk("drop_ready", 32'(bus.drop_ready), 1);
    e.ok  = (col < 7) && (mh[col] < 6) && (pl != 0);
    e.row = e.ok ? 3'(mh[col]) : mlast;
    if (e.ok) begin
      mcell[mh[col]][col] = 2'(pl);
      mh[col]++;
      mlast = e.row;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1 bus.drop_valid = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus.drop_done) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
    chk("drop_done_seen", 32'(seen), 1);
    chk("drop_latency", 32'(lat), 2);
    if (seen && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk($sformatf("drop_ok col%0d", col), 32'(bus.drop_ok), 32'(e.ok));
      chk($sformatf("drop_row col%0d", col), 32'(bus.drop_row), 32'(e.row));
    end
    @(negedge clk);
    chk("drop_done_pulse", 32'(bus.drop_done), 0);
  endtask

  task automatic do_clear();
    int busy;
    @(negedge clk);
    bus.clear_req = 1'b1;
    @(posedge clk);
    #1 bus.clear_req = 1'b0;
    busy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.clear_busy) break;
      busy++;
    end
    chk("clear_cycles", 32'(busy), 6);
    chk("clear_done", 32'(bus.clear_done), 1);
    model_clear();
  endtask

  initial begin
    int busy;
    bus.drop_valid = 0; bus.drop_col = 0; bus.drop_player = 0;
    bus.clear_req = 0; bus.read_row = 0; bus.read_col = 0;
    bus.winning_row = 0; bus.winning_col = 0; bus.w_winning_pieces = 0;
    model_clear();
    mlast = 3'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_drop_done", 32'(bus.drop_done), 0);
    chk("rst_drop_ok", 32'(bus.drop_ok), 0);
    chk("rst_drop_row", 32'(bus.drop_row), 0);
    chk("rst_clear_busy", 32'(bus.clear_busy), 0);
    chk("rst_clear_done", 32'(bus.clear_done), 0);
    chk("rst_drop_ready", 32'(bus.drop_ready), 1);
    rd(0, 0);
    rd(7, 7);

    // Two stacked drops, then same-cycle read.
    drop(3, 1);
    drop(3, 2);
    @(negedge clk);
    rd(1, 3);
    rd(0, 3);

    // Column overflow and illegal requests.
    for (int i = 0; i < 7; i++) drop(0, (i % 3) + 1);
    drop(7, 1);
    drop(1, 0);
    check_all();

    // Mark writes on the diagonal plus one out-of-range row.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.w_winning_pieces = 1'b1;
      bus.winning_row = (i < 4) ? 3'(i) : 3'd6;
      bus.winning_col = (i < 4) ? 3'(i) : 3'd0;
      if (i < 4) mmark[i][i] = 1'b1;
    end
    @(negedge clk);
    bus.w_winning_pieces = 1'b0;
    check_all();

    // Clear beats a simultaneous drop; marks during the sweep are ignored.
    @(negedge clk);
    bus.clear_req = 1'b1;
    bus.drop_valid = 1'b1; bus.drop_col = 3'd2; bus.drop_player = 2'd1;
    #1 chk("ready_under_clear", 32'(bus.drop_ready), 0);
    @(posedge clk);
    #1 begin bus.clear_req = 1'b0; bus.drop_valid = 1'b0; end
    busy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.clear_busy) break;
      busy++;
      bus.w_winning_pieces = (busy == 3);
      bus.winning_row = 3'd0;
      bus.winning_col = 3'd5;
    end
    bus.w_winning_pieces = 1'b0;
    chk("clear_cycles", 32'(busy), 6);
    chk("clear_done", 32'(bus.clear_done), 1);
    @(negedge clk);
    chk("clear_done_pulse", 32'(bus.clear_done), 0);
    model_clear();
    check_all();
    drop(2, 1);

    // Reset in the middle of a sweep aborts it silently.
    drop(4, 2);
    drop(4, 3);
    @(negedge clk);
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_clear_done", 32'(bus.clear_done), 0);
    end
    rst_n = 1'b1;
    model_clear();
    mlast = 3'd0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.clear_done), 0);
      chk("abort_busy", 32'(bus.clear_busy), 0);
    end
    chk("abort_drop_row", 32'(bus.drop_row), 0);
    check_all();

`ifdef BOARD_STORE_FULL_DETECT_EN
    // Full-board detection.
    chk("full_init", 32'(board_full), 0);
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) begin
        if (c == 6 && r == 5) chk("full_before_last", 32'(board_full), 0);
        drop(c, (r % 3) + 1);
      end
    chk("full_set", 32'(board_full), 1);
    drop(5, 1);
    do_clear();
    @(negedge clk);
    chk("full_cleared", 32'(board_full), 0);
`else
    do_clear();
`endif
    drop(6, 3);
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/board_store.md
Name: board_store

Overview:
- Board memory responder for the connect-four datapath. Holds one 2-bit piece code per cell and one win-highlight bit per cell.
- Serves the checker's read port with a zero-latency combinational read of the registered read_row/read_col.
- Accepts the checker's winning-piece mark writes.
- Executes column drops through a valid/ready request with a done pulse.
- Executes a multi-cycle board clear.

Parameters:
- ROWS, 6, number of implemented rows (1..8); row 0 is the bottom.
- COLS, 7, number of implemented columns (1..8).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- drop_valid  in  1  drop request
- drop_ready  out  1  drop request acceptable this cycle
- drop_col  in  3  target column of drop
- drop_player  in  2  piece code to place (01/10/11; 00 illegal)
- drop_done  out  1  one-cycle pulse: drop processed
- drop_ok  out  1  qualifies drop_done: 1 = placed, 0 = rejected
- drop_row  out  3  row where the piece landed; valid with drop_done & drop_ok
- clear_req  in  1  request board clear
- clear_busy  out  1  clear sweep in progress
- clear_done  out  1  one-cycle pulse at end of sweep
- read_row  in  3  read address row
- read_col  in  3  read address column
- data_out  out  2  piece code at read_row/read_col
- win_out  out  1  highlight bit at read_row/read_col
- winning_row  in  3  mark address row
- winning_col  in  3  mark address column
- w_winning_pieces  in  1  mark write enable
- board_full  out  1  all columns full (optional feature only)

Behaviour:
- Reset (rst_n low at posedge): all cells 00, all marks 0, all column heights 0, state ST_IDLE. Outputs: drop_done=0, drop_ok=0, drop_row=0, clear_busy=0, clear_done=0. A reset in the middle of a drop or clear aborts it with no done pulse.
- Read port: combinational; no clock latency.
  - Out-of-range address (row>=ROWS or col>=COLS) returns data_out=00, win_out=0.
  - 3-bit wrap-around addresses are decoded as given; no correction.
  - Reads see the current register contents; a write at the same edge is visible from the next cycle.
- Column heights: one counter per column, 0..ROWS. The height is the next free row.
- States: ST_IDLE, ST_DROP, ST_CLEAR.
- drop_ready = (state==ST_IDLE) & !clear_req.
- ST_IDLE:
  - clear_req → ST_CLEAR, clear-row counter set to 0. clear_req has priority over drop_valid.
  - Otherwise drop_valid & drop_ready: capture drop_col and drop_player → ST_DROP.
- ST_DROP (exactly one cycle) → ST_IDLE. In that cycle the following are registered, so they are visible in the next cycle: drop_done=1, and either
  - Accept (drop_col<COLS, height<ROWS, drop_player!=00): write the cell (height, col) with drop_player; height+1; drop_row=old height; drop_ok=1.
  - Reject (any other case): drop_ok=1 is not set (drop_ok=0), no write, drop_row unchanged.
  - Accept-to-done latency is 2 edges. Throughput is one drop every 2 cycles.
- ST_CLEAR:
  - clear_busy=1.
  - Each cycle, zero all cells and marks of the counter row, then increment the counter.
  - After row ROWS-1: zero all heights, pulse clear_done (visible in the next cycle, same time as clear_busy falls), → ST_IDLE.
  - Takes ROWS cycles. clear_req during a clear is ignored.
- Mark writes:
  - On any posedge with w_winning_pieces=1 and state!=ST_CLEAR, set mark(winning_row, winning_col)=1.
  - Out-of-range mark writes are ignored.
  - Marks are held in a separate array from pieces, so a mark write and a drop write in the same cycle both take effect, even on the same cell.
  - Marks are cleared only by reset or a clear.
- drop_done and clear_done are single-cycle pulses, 0 otherwise.

Optional Feature:
- Macro BOARD_STORE_FULL_DETECT_EN.
- Defined: board_full output present, registered; 1 when every column height == ROWS; cleared by reset or by clear completion; updates the cycle after the filling drop's done.
- Not defined: board_full port absent and no related logic.

Test Plan:
- Reset, read (0,0) and (7,7) → data_out=00, win_out=0; drop_ready=1.
- Drop col 3 player 01, then col 3 player 10 → done pulses 2 cycles after acceptance, drop_row 0 then 1, drop_ok=1; read (1,3) → 10 in the same cycle the address is applied.
- 7 drops into col 0 → first 6 ok with rows 0..5; 7th drop_ok=0, height stays 6; drop col 7 → drop_ok=0; drop_player 00 → drop_ok=0, no write.
- Assert w_winning_pieces 4 cycles with (0,0),(1,1),(2,2),(3,3) → win_out=1 at those cells only; mark at (6,0) ignored.
- clear_req and drop_valid in the same cycle → drop_ready=0, clear_busy for 6 cycles, clear_done pulse, all cells and marks 0, next drop lands at row 0; rst_n low mid-clear → no clear_done, board zeroed.
- With BOARD_STORE_FULL_DETECT_EN, fill all 42 cells → board_full=1 after the last done; clear → board_full=0.
